mdu_ctrl: RTL

- Multiply/divide unit controller that sits beside the ALU in the E stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo requests and owns the HI/LO registers.
- Models the multi-cycle latency of the multiplier and divider with a busy counter.
- Raises a stall request so a later HI/LO-using instruction stays in D until the result is ready.

---
 rtl/mdu_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the E stage.
// Owns the architectural HI/LO registers. Products and quotients are formed
// at issue into pending registers and committed to HI/LO only after a busy
// count that mimics the latency of an iterative multiplier/divider, so
// software sees realistic timing and the D stage can be held off.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_in1,
   input  logic [31:0] md_in2,
   input  logic        md_use,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Counter holds "cycles remaining minus one", so it is loaded with N-1.
   localparam logic [3:0] LP_MULT_LD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] LP_DIV_LD  = 4'(DIV_CYCLES - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        w_busy;
   logic        w_stall;
   logic        w_is_muldiv;
   logic [63:0] w_smul;
   logic [63:0] w_umul;
   logic [63:0] w_sdiv;
   logic [63:0] w_udiv;

   // Division result packed as {remainder, quotient}. Divide-by-zero returns
   // an all-ones quotient and the dividend as remainder; the one signed
   // overflow case (most-negative / -1) is pinned so the hardware never
   // relies on an undefined quotient.
   function automatic logic [63:0] f_div(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        is_signed);
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      logic [63:0]        res;
      if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res = {32'd0, 32'h8000_0000};
      end else if (is_signed) begin
         sq  = $signed(a) / $signed(b);
         sr  = $signed(a) % $signed(b);
         res = {sr, sq};
      end else begin
         res = {a % b, a / b};
      end
      return res;
   endfunction

   assign w_is_muldiv = start & ~md_op[2];
   assign w_smul = $signed({{32{md_in1[31]}}, md_in1}) * $signed({{32{md_in2[31]}}, md_in2});
   assign w_umul = {32'd0, md_in1} * {32'd0, md_in2};
   assign w_sdiv = f_div(md_in1, md_in2, 1'b1);
   assign w_udiv = f_div(md_in1, md_in2, 1'b0);

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next state: mul/div issue enters RUN, counter expiry returns to IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_is_muldiv)   w_next_state = S_RUN;
         S_RUN:  if (r_cnt == 4'd0) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs: busy is a decode of the state register; the stall also covers
   // the issue cycle, before busy has had a chance to rise.
   always_comb begin
      w_busy  = (r_state == S_RUN);
      w_stall = md_use & (w_busy | w_is_muldiv);
   end

   // Datapath: capture results at issue, count down, commit HI/LO at expiry.
   // Requests arriving while RUN are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= 4'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (md_op)
                     3'd0: begin
                        {r_pend_hi, r_pend_lo} <= w_smul;
                        r_cnt <= LP_MULT_LD;
                     end
                     3'd1: begin
                        {r_pend_hi, r_pend_lo} <= w_umul;
                        r_cnt <= LP_MULT_LD;
                     end
                     3'd2: begin
                        {r_pend_hi, r_pend_lo} <= w_sdiv;
                        r_cnt <= LP_DIV_LD;
                     end
                     3'd3: begin
                        {r_pend_hi, r_pend_lo} <= w_udiv;
                        r_cnt <= LP_DIV_LD;
                     end
                     3'd4:    r_hi <= md_in1;
                     3'd5:    r_lo <= md_in1;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (r_cnt == 4'd0) begin
                  r_hi <= r_pend_hi;
                  r_lo <= r_pend_lo;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = w_busy;
   assign stall_req = w_stall;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule
